osd_mam_sram_if: RTL and testbench

Memory-side responder for the MAM memory-access interface. It accepts single and burst read/write requests issued by the debug memory-access module and executes them on a synchronous single-port SRAM with 1-cycle read latency. Read data passes through a 2-entry output buffer so bursts sustain 1 beat/cycle under `read_ready` backpressure. It sits between the debug subsystem and one on-chip memory region.

---
 rtl/osd_mam_sram_if_if.sv | 32 +++
 rtl/osd_mam_sram_if.sv | 156 +++++++++++++++
 tb/tb_osd_mam_sram_if.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/osd_mam_sram_if_if.sv
// MAM memory-access bus: request, write-beat and read-beat channels between
// the debug memory-access module (master) and a memory responder (slave).
interface osd_mam_sram_if_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_rw;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_burst;
  logic [13:0]             req_beats;
  logic                    write_valid;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [DATA_WIDTH/8-1:0] write_strb;
  logic                    write_ready;
  logic                    read_valid;
  logic [DATA_WIDTH-1:0]   read_data;
  logic                    read_ready;

  modport master (
    output req_valid, req_rw, req_addr, req_burst, req_beats,
           write_valid, write_data, write_strb, read_ready,
    input  req_ready, write_ready, read_valid, read_data
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_burst, req_beats,
           write_valid, write_data, write_strb, read_ready,
    output req_ready, write_ready, read_valid, read_data
  );
endinterface

// File: rtl/osd_mam_sram_if.sv
// MAM responder for a 1-cycle-latency single-port SRAM with a 2-entry read buffer.
// Optional macro OSD_MAM_SRAM_BOUNDS_EN: per-beat range check, out-of-range beats skip the SRAM.
module osd_mam_sram_if #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    SRAM_AW    = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  osd_mam_sram_if_if.slave        mam,
  output logic                    sram_ce,
  output logic                    sram_we,
  output logic [SRAM_AW-1:0]      sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  output logic [DATA_WIDTH/8-1:0] sram_be,
  input  logic [DATA_WIDTH-1:0]   sram_rdata
);

  localparam int BW  = DATA_WIDTH / 8;
  localparam int BSH = $clog2(BW);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t                state;
  logic                  req_ready_q;
  logic [BW-1:0]         strb_q;
  logic                  burst_q;
  logic [SRAM_AW-1:0]    waddr;
  logic [13:0]           remaining;
  logic                  oob_q;
  logic                  inflight;
  logic                  inflight_oob;
  logic [1:0]            count;
  logic                  wptr;
  logic                  rptr;
  logic [DATA_WIDTH-1:0] fifo_mem [2];

  logic [ADDR_WIDTH-1:0] byte_off;
  logic [SRAM_AW-1:0]    req_waddr;
  logic [13:0]           req_remaining;
  logic                  req_oob;
  logic                  adv_oob;
  logic                  wr_fire;
  logic                  pop;
  logic [2:0]            occ;
  logic                  rd_issue;
  logic                  rd_done;

  assign byte_off      = mam.req_addr - BASE_ADDR;
  assign req_waddr     = SRAM_AW'(byte_off >> BSH);
  assign req_remaining = (mam.req_burst && (mam.req_beats != 14'd0)) ? mam.req_beats : 14'd1;

`ifdef OSD_MAM_SRAM_BOUNDS_EN
  // Stepping past the top word makes the rest of the burst out of range instead of wrapping.
  assign req_oob = (mam.req_addr < BASE_ADDR) || (((byte_off >> BSH) >> SRAM_AW) != '0);
  assign adv_oob = oob_q | (&waddr);
`else
  assign req_oob = 1'b0;
  assign adv_oob = oob_q;
`endif

  // Issue only when the buffer can absorb the word returning next cycle.
  assign wr_fire  = (state == WRITE) && mam.write_valid;
  assign pop      = (count != 2'd0) && mam.read_ready;
  assign occ      = {1'b0, count} + {2'b00, inflight};
  assign rd_issue = (state == READ) && (remaining != 14'd0) && (occ < (3'd2 + {2'b00, pop}));
  assign rd_done  = (state == READ) && (remaining == 14'd0) && !inflight &&
                    ((count == 2'd0) || ((count == 2'd1) && pop));

  assign sram_ce    = (wr_fire || rd_issue) && !oob_q;
  assign sram_we    = wr_fire && !oob_q;
  assign sram_addr  = sram_ce ? waddr : '0;
  assign sram_wdata = sram_we ? mam.write_data : '0;
  assign sram_be    = sram_we ? (burst_q ? {BW{1'b1}} : strb_q) : '0;

  assign mam.req_ready   = req_ready_q;
  assign mam.write_ready = (state == WRITE);
  assign mam.read_valid  = (count != 2'd0);
  assign mam.read_data   = (count != 2'd0) ? fifo_mem[rptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready_q <= 1'b0;
      strb_q      <= '0;
      burst_q     <= 1'b0;
      waddr       <= '0;
      remaining   <= '0;
      oob_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (mam.req_valid && req_ready_q) begin
            strb_q      <= mam.write_strb;
            burst_q     <= mam.req_burst;
            waddr       <= req_waddr;
            remaining   <= req_remaining;
            oob_q       <= req_oob;
            req_ready_q <= 1'b0;
            state       <= mam.req_rw ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wr_fire) begin
            waddr     <= waddr + SRAM_AW'(1);
            remaining <= remaining - 14'd1;
            oob_q     <= adv_oob;
            if (remaining == 14'd1) begin
              state       <= IDLE;
              req_ready_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (rd_issue) begin
            waddr     <= waddr + SRAM_AW'(1);
            remaining <= remaining - 14'd1;
            oob_q     <= adv_oob;
          end
          if (rd_done) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Read return: SRAM data lands one cycle after issue and is pushed into the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight     <= 1'b0;
      inflight_oob <= 1'b0;
      count        <= 2'd0;
      wptr         <= 1'b0;
      rptr         <= 1'b0;
    end else begin
      inflight     <= rd_issue;
      inflight_oob <= oob_q;
      count        <= count + {1'b0, inflight} - {1'b0, pop};
      if (inflight) wptr <= ~wptr;
      if (pop)      rptr <= ~rptr;
    end
  end

  always_ff @(posedge clk) begin
    if (inflight) fifo_mem[wptr] <= inflight_oob ? '0 : sram_rdata;
  end

endmodule

// File: tb/tb_osd_mam_sram_if.sv
// Directed bench for osd_mam_sram_if: DATA_WIDTH=32, SRAM_AW=4, BASE_ADDR=0x1000,
// with a behavioural 1-cycle-latency SRAM and an access monitor.
module tb_osd_mam_sram_if;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic        init_mem;
  logic        sram_ce;
  logic        sram_we;
  logic [3:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_be;
  logic [31:0] sram_rdata;
  logic [31:0] mem [16];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_cyc   = 0;
  int first_cyc;
  int last_cyc;
  int got;
  int mark;
  logic [31:0] rd_buf [16];

  logic [3:0]  acc_addr_q  [$];
  logic        acc_we_q    [$];
  logic [3:0]  acc_be_q    [$];
  logic [31:0] acc_wdata_q [$];

  osd_mam_sram_if_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) mam ();

  osd_mam_sram_if #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .SRAM_AW   (4),
    .BASE_ADDR (BASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mam       (mam.slave),
    .sram_ce   (sram_ce),
    .sram_we   (sram_we),
    .sram_addr (sram_addr),
    .sram_wdata(sram_wdata),
    .sram_be   (sram_be),
    .sram_rdata(sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: byte-enabled write, registered read.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hDEAD_0000 + 32'(i);
    end else if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  always @(negedge clk) begin
    if (sram_ce) begin
      acc_addr_q.push_back(sram_addr);
      acc_we_q.push_back(sram_we);
      acc_be_q.push_back(sram_be);
      acc_wdata_q.push_back(sram_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send_req(input logic rw, input logic [31:0] addr, input logic burst,
                          input logic [13:0] beats, input logic [3:0] strb);
    bit ok;
    @(posedge clk); #1;
    mam.req_valid  = 1'b1;
    mam.req_rw     = rw;
    mam.req_addr   = addr;
    mam.req_burst  = burst;
    mam.req_beats  = beats;
    mam.write_strb = strb;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mam.req_ready) begin
        ok = 1'b1;
        hs_cyc = cyc;
        break;
      end
    end
    check_eq("req_handshake", 64'(ok), 64'd1);
    @(posedge clk); #1;
    mam.req_valid = 1'b0;
  endtask

  task automatic write_beats(input int n, input logic [31:0] base_data,
                             input logic [15:0] pat, input int plen);
    int acc;
    acc = 0;
    for (int i = 0; i < 64 && acc < n; i++) begin
      mam.write_valid = pat[i % plen];
      mam.write_data  = base_data + 32'(acc);
      @(negedge clk);
      if (mam.write_valid && mam.write_ready) acc++;
      @(posedge clk); #1;
    end
    mam.write_valid = 1'b0;
    check_eq("write_beat_count", 64'(acc), 64'(n));
  endtask

  task automatic read_beats(input int n, input logic [15:0] pat, input int plen);
    got = 0;
    first_cyc = -1;
    last_cyc = -1;
    for (int i = 0; i < 100 && got < n; i++) begin
      mam.read_ready = pat[i % plen];
      @(negedge clk);
      if (mam.read_valid && first_cyc < 0) first_cyc = cyc;
      if (mam.read_valid && mam.read_ready) begin
        rd_buf[got] = mam.read_data;
        got++;
        last_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    mam.read_ready = 1'b0;
  endtask

  task automatic check_no_read_valid(input string tag, input int ncyc);
    int extra;
    extra = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (mam.read_valid) extra++;
    end
    check_eq(tag, 64'(extra), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"},   64'(mam.req_ready),   64'd0);
    check_eq({tag, "_write_ready"}, 64'(mam.write_ready), 64'd0);
    check_eq({tag, "_read_valid"},  64'(mam.read_valid),  64'd0);
    check_eq({tag, "_read_data"},   64'(mam.read_data),   64'd0);
    check_eq({tag, "_sram_ce"},     64'(sram_ce),         64'd0);
    check_eq({tag, "_sram_we"},     64'(sram_we),         64'd0);
    check_eq({tag, "_sram_addr"},   64'(sram_addr),       64'd0);
    check_eq({tag, "_sram_wdata"},  64'(sram_wdata),      64'd0);
    check_eq({tag, "_sram_be"},     64'(sram_be),         64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n           = 1'b0;
    init_mem        = 1'b1;
    mam.req_valid   = 1'b0;
    mam.req_rw      = 1'b0;
    mam.req_addr    = '0;
    mam.req_burst   = 1'b0;
    mam.req_beats   = '0;
    mam.write_valid = 1'b0;
    mam.write_data  = '0;
    mam.write_strb  = '0;
    mam.read_ready  = 1'b0;

    // Reset values and first cycle after release
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst_n    = 1'b1;
    init_mem = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_release_req_ready", 64'(mam.req_ready), 64'd1);

    // Single strobed write to word 2, then readback
    mark = acc_addr_q.size();
    send_req(1'b1, BASE + 32'd8, 1'b0, 14'd0, 4'b0011);
    write_beats(1, 32'hA5A5_1234, 16'h0001, 1);
    check_eq("sw_access_count", 64'(acc_addr_q.size() - mark), 64'd1);
    check_eq("sw_addr",  64'(acc_addr_q[mark]),  64'd2);
    check_eq("sw_we",    64'(acc_we_q[mark]),    64'd1);
    check_eq("sw_be",    64'(acc_be_q[mark]),    64'h3);
    check_eq("sw_wdata", 64'(acc_wdata_q[mark]), 64'hA5A5_1234);
    send_req(1'b0, BASE + 32'd8, 1'b0, 14'd0, 4'b0000);
    read_beats(1, 16'h0001, 1);
    check_eq("sw_readback_count", 64'(got), 64'd1);
    check_eq("sw_readback_data", 64'(rd_buf[0]), 64'hDEAD_1234);

    // Burst write with gaps in write_valid, words 4..7
    mark = acc_addr_q.size();
    send_req(1'b1, BASE + 32'd16, 1'b1, 14'd4, 4'b0001);
    write_beats(4, 32'h1000_0000, 16'b101101, 6);
    @(negedge clk);
    check_eq("bw_req_ready_after", 64'(mam.req_ready), 64'd1);
    check_eq("bw_write_ready_after", 64'(mam.write_ready), 64'd0);
    check_eq("bw_access_count", 64'(acc_addr_q.size() - mark), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("bw_addr%0d", k),  64'(acc_addr_q[mark+k]),  64'(4 + k));
      check_eq($sformatf("bw_be%0d", k),    64'(acc_be_q[mark+k]),    64'hF);
      check_eq($sformatf("bw_wdata%0d", k), 64'(acc_wdata_q[mark+k]), 64'(32'h1000_0000 + 32'(k)));
    end

    // 8-beat read of words 4..11 under backpressure 1,0,0,1,1,0,1
    send_req(1'b0, BASE + 32'd16, 1'b1, 14'd8, 4'b0000);
    read_beats(8, 16'b1011001, 7);
    check_eq("br_bp_count", 64'(got), 64'd8);
    check_eq("br_bp_first_valid", 64'(first_cyc - hs_cyc), 64'd3);
    for (int k = 0; k < 8; k++)
      check_eq($sformatf("br_bp_data%0d", k), 64'(rd_buf[k]),
               64'((k < 4) ? (32'h1000_0000 + 32'(k)) : (32'hDEAD_0004 + 32'(k))));
    check_no_read_valid("br_bp_no_extra", 3);

    // Same read with read_ready held high: 8 beats in 8 consecutive cycles
    send_req(1'b0, BASE + 32'd16, 1'b1, 14'd8, 4'b0000);
    read_beats(8, 16'h0001, 1);
    check_eq("br_full_count", 64'(got), 64'd8);
    check_eq("br_full_first_valid", 64'(first_cyc - hs_cyc), 64'd3);
    check_eq("br_full_span", 64'(last_cyc - first_cyc), 64'd7);
    check_eq("br_full_data7", 64'(rd_buf[7]), 64'hDEAD_000B);
    @(negedge clk);
    check_eq("br_full_req_ready_after", 64'(mam.req_ready), 64'd1);

`ifndef OSD_MAM_SRAM_BOUNDS_EN
    // Wrap-around: 3-beat read starting at word 15
    mark = acc_addr_q.size();
    send_req(1'b0, BASE + 32'd60, 1'b1, 14'd3, 4'b0000);
    read_beats(3, 16'h0001, 1);
    check_eq("wrap_access_count", 64'(acc_addr_q.size() - mark), 64'd3);
    check_eq("wrap_addr0", 64'(acc_addr_q[mark]),   64'd15);
    check_eq("wrap_addr1", 64'(acc_addr_q[mark+1]), 64'd0);
    check_eq("wrap_addr2", 64'(acc_addr_q[mark+2]), 64'd1);
    check_eq("wrap_data0", 64'(rd_buf[0]), 64'hDEAD_000F);
    check_eq("wrap_data1", 64'(rd_buf[1]), 64'hDEAD_0000);
    check_eq("wrap_data2", 64'(rd_buf[2]), 64'hDEAD_0001);
`else
    // Out-of-range: 2-beat write from word 15, second beat discarded
    mark = acc_addr_q.size();
    send_req(1'b1, BASE + 32'd60, 1'b1, 14'd2, 4'b0000);
    write_beats(2, 32'h5555_0000, 16'h0001, 1);
    check_eq("oob_wr_access_count", 64'(acc_addr_q.size() - mark), 64'd1);
    check_eq("oob_wr_addr", 64'(acc_addr_q[mark]), 64'd15);
    mark = acc_addr_q.size();
    send_req(1'b0, BASE + 32'd60, 1'b1, 14'd2, 4'b0000);
    read_beats(2, 16'h0001, 1);
    check_eq("oob_rd_count", 64'(got), 64'd2);
    check_eq("oob_rd_access_count", 64'(acc_addr_q.size() - mark), 64'd1);
    check_eq("oob_rd_data0", 64'(rd_buf[0]), 64'h5555_0000);
    check_eq("oob_rd_data1", 64'(rd_buf[1]), 64'd0);
`endif

    // Reset asserted while the 3rd beat of a 6-beat read is presented
    send_req(1'b0, BASE + 32'd32, 1'b1, 14'd6, 4'b0000);
    read_beats(2, 16'h0001, 1);
    check_eq("mid_rst_pre_count", 64'(got), 64'd2);
    check_eq("mid_rst_3rd_valid", 64'(mam.read_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_rst_req_ready", 64'(mam.req_ready), 64'd1);
    check_eq("mid_rst_read_valid", 64'(mam.read_valid), 64'd0);
    mark = acc_addr_q.size();
    check_no_read_valid("mid_rst_no_stale", 4);
    check_eq("mid_rst_no_access", 64'(acc_addr_q.size() - mark), 64'd0);
    send_req(1'b0, BASE + 32'd32, 1'b0, 14'd0, 4'b0000);
    read_beats(1, 16'h0001, 1);
    check_eq("post_rst_read_count", 64'(got), 64'd1);
    check_eq("post_rst_read_data", 64'(rd_buf[0]), 64'hDEAD_0008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
